// File: rtl/gt_reset_sequencer_if.sv
// GT-side control/status bundle for the GTX channel reset sequencer.
interface gt_reset_sequencer_if;
  logic       SOFT_RESET_IN;
  logic       GT0_CPLLLOCK_IN;
  logic       GT0_TXRESETDONE_IN;
  logic       GT0_RXRESETDONE_IN;
  logic       GT0_CPLLRESET_OUT;
  logic       GT0_GTTXRESET_OUT;
  logic       GT0_GTRXRESET_OUT;
  logic       GT0_TXUSERRDY_OUT;
  logic       GT0_RXUSERRDY_OUT;
  logic       TX_FSM_RESET_DONE_OUT;
  logic       RX_FSM_RESET_DONE_OUT;
  logic       FAIL_OUT;
  logic [3:0] RETRY_COUNT_OUT;
  logic [2:0] STATE_OUT;

  // Drives the GT status inputs and observes the sequencer outputs.
  modport master (
    output SOFT_RESET_IN, GT0_CPLLLOCK_IN, GT0_TXRESETDONE_IN, GT0_RXRESETDONE_IN,
    input  GT0_CPLLRESET_OUT, GT0_GTTXRESET_OUT, GT0_GTRXRESET_OUT,
           GT0_TXUSERRDY_OUT, GT0_RXUSERRDY_OUT, TX_FSM_RESET_DONE_OUT,
           RX_FSM_RESET_DONE_OUT, FAIL_OUT, RETRY_COUNT_OUT, STATE_OUT
  );

  // The sequencer side.
  modport slave (
    input  SOFT_RESET_IN, GT0_CPLLLOCK_IN, GT0_TXRESETDONE_IN, GT0_RXRESETDONE_IN,
    output GT0_CPLLRESET_OUT, GT0_GTTXRESET_OUT, GT0_GTRXRESET_OUT,
           GT0_TXUSERRDY_OUT, GT0_RXUSERRDY_OUT, TX_FSM_RESET_DONE_OUT,
           RX_FSM_RESET_DONE_OUT, FAIL_OUT, RETRY_COUNT_OUT, STATE_OUT
  );
endinterface

// File: rtl/gt_reset_sequencer.sv
// Startup/reset sequencer for one GTX channel: settle, CPLL reset, lock wait,
// GT TX/RX reset, USERRDY, resetdone wait; retries on timeout or lock loss.
module gt_reset_sequencer #(
  parameter int unsigned STARTUP_WAIT_CYCLES = 75,
  parameter int unsigned CPLLRST_CYCLES      = 8,
  parameter int unsigned GTRST_CYCLES        = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 75000,
  parameter int unsigned DONE_TIMEOUT_CYCLES = 150000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                  STABLE_CLOCK_IN,
  input  logic                  RESET_N_IN,
  gt_reset_sequencer_if.slave   gt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(STARTUP_WAIT_CYCLES, CPLLRST_CYCLES),
                                              max2(GTRST_CYCLES, LOCK_TIMEOUT_CYCLES)),
                                         DONE_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned RTY_W   = 4;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_CPLL_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_GT_RST    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d, retry_inc;
  logic [2:0]         meta_q, meta_d, sync_q, sync_d;
  logic               cpllreset_q, cpllreset_d;
  logic               gtreset_q, gtreset_d;
  logic               userrdy_q, userrdy_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               lock_s, txdone_s, rxdone_s;
  logic               timeout_lock, timeout_done, last_cpll, last_gt, last_init;
  state_e             timeout_state;

  assign lock_s   = sync_q[2];
  assign txdone_s = sync_q[1];
  assign rxdone_s = sync_q[0];

  // Two-stage synchroniser for CPLLLOCK / TXRESETDONE / RXRESETDONE.
  always_comb begin
    meta_d = {gt.GT0_CPLLLOCK_IN, gt.GT0_TXRESETDONE_IN, gt.GT0_RXRESETDONE_IN};
    sync_d = meta_q;
  end

  // Next state, shared counter, retry count and registered outputs.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    retry_inc     = (retry_q == '1) ? retry_q : retry_q + RTY_W'(1);
    timeout_state = (32'(retry_inc) >= MAX_RETRIES) ? ST_FAIL : ST_CPLL_RST;
    last_init     = (cnt_q == CNT_W'(STARTUP_WAIT_CYCLES - 1));
    last_cpll     = (cnt_q == CNT_W'(CPLLRST_CYCLES - 1));
    last_gt       = (cnt_q == CNT_W'(GTRST_CYCLES - 1));
    timeout_lock  = (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
    timeout_done  = (cnt_q == CNT_W'(DONE_TIMEOUT_CYCLES - 1));

    if (gt.SOFT_RESET_IN) begin
      state_d = ST_INIT;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_INIT:      if (last_init) state_d = ST_CPLL_RST;
        ST_CPLL_RST:  if (last_cpll) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (timeout_lock) begin
            retry_d = retry_inc;
            state_d = timeout_state;
          end else if (lock_s) begin
            state_d = ST_GT_RST;
          end
        end
        ST_GT_RST:    if (last_gt) state_d = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (!lock_s) begin
            retry_d = retry_inc;
            state_d = ST_CPLL_RST;
          end else if (timeout_done) begin
            retry_d = retry_inc;
            state_d = timeout_state;
          end else if (txdone_s && rxdone_s) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!lock_s || !txdone_s || !rxdone_s) begin
            retry_d = retry_inc;
            state_d = ST_CPLL_RST;
          end
        end
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_INIT;
      endcase
    end

    // Counter restarts on every state change and on a held soft reset; saturates otherwise.
    if (gt.SOFT_RESET_IN || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q == '1)                         cnt_d = cnt_q;
    else                                          cnt_d = cnt_q + CNT_W'(1);

    cpllreset_d = (state_d == ST_CPLL_RST) || (state_d == ST_FAIL);
    gtreset_d   = (state_d == ST_INIT) || (state_d == ST_GT_RST) || (state_d == ST_FAIL);
    userrdy_d   = (state_d == ST_WAIT_DONE) || (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge STABLE_CLOCK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      retry_q     <= '0;
      meta_q      <= '0;
      sync_q      <= '0;
      cpllreset_q <= 1'b0;
      gtreset_q   <= 1'b1;
      userrdy_q   <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      cpllreset_q <= cpllreset_d;
      gtreset_q   <= gtreset_d;
      userrdy_q   <= userrdy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign gt.GT0_CPLLRESET_OUT     = cpllreset_q;
  assign gt.GT0_GTTXRESET_OUT     = gtreset_q;
  assign gt.GT0_GTRXRESET_OUT     = gtreset_q;
  assign gt.GT0_TXUSERRDY_OUT     = userrdy_q;
  assign gt.GT0_RXUSERRDY_OUT     = userrdy_q;
  assign gt.TX_FSM_RESET_DONE_OUT = done_q;
  assign gt.RX_FSM_RESET_DONE_OUT = done_q;
  assign gt.FAIL_OUT              = fail_q;
  assign gt.RETRY_COUNT_OUT       = retry_q;
  assign gt.STATE_OUT             = state_q;

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Directed bench for gt_reset_sequencer with a small behavioural GT model.
module tb_gt_reset_sequencer;

  logic clk;
  logic rst_n;
  gt_reset_sequencer_if bus ();

  gt_reset_sequencer #(
    .STARTUP_WAIT_CYCLES (16),
    .CPLLRST_CYCLES      (4),
    .GTRST_CYCLES        (4),
    .LOCK_TIMEOUT_CYCLES (100),
    .DONE_TIMEOUT_CYCLES (200),
    .MAX_RETRIES         (2)
  ) dut (
    .STABLE_CLOCK_IN (clk),
    .RESET_N_IN      (rst_n),
    .gt              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GT model: lock 20 cycles after CPLLRESET falls, resetdone 30 cycles after GT resets fall.
  logic lock_en, tx_en, rx_en, lock_kill;
  int   lock_cnt, done_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      lock_cnt <= 0;
    else if (bus.GT0_CPLLRESET_OUT)  lock_cnt <= 0;
    else if (lock_cnt < 100000)      lock_cnt <= lock_cnt + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          done_cnt <= 0;
    else if (bus.GT0_GTTXRESET_OUT || bus.GT0_GTRXRESET_OUT) done_cnt <= 0;
    else if (done_cnt < 100000)                          done_cnt <= done_cnt + 1;
  end

  assign bus.GT0_CPLLLOCK_IN    = lock_en && !lock_kill && (lock_cnt >= 20);
  assign bus.GT0_TXRESETDONE_IN = tx_en && (done_cnt >= 30);
  assign bus.GT0_RXRESETDONE_IN = rx_en && (done_cnt >= 30);

  typedef struct {
    bit lock_en;
    bit tx_en;
    bit rx_en;
    int cycles;
    int exp_state;
    int exp_retry;
    int exp_fail;
    int exp_done;
  } vec_t;

  vec_t vecs [4];
  int   total, bad;
  bit   txdone_seen;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.TX_FSM_RESET_DONE_OUT) txdone_seen = 1'b1;
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n;
    n = 0;
    while (int'(bus.STATE_OUT) != st && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(bus.STATE_OUT), st);
  endtask

  task automatic dwell(input int st, input int budget, output int n);
    n = 0;
    while (int'(bus.STATE_OUT) == st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic soft_pulse();
    bus.SOFT_RESET_IN = 1'b1;
    tick();
    bus.SOFT_RESET_IN = 1'b0;
  endtask

  initial begin
    int seq [8];
    int nseq, prev, cpll_hi, gt_hi, n;
    bit first4;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 300, 5, 0, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 300, 7, 2, 1, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 600, 7, 2, 1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 600, 7, 2, 1, 0};

    total = 0; bad = 0; txdone_seen = 1'b0;
    rst_n = 1'b0;
    bus.SOFT_RESET_IN = 1'b0;
    lock_en = 1'b1; tx_en = 1'b1; rx_en = 1'b1; lock_kill = 1'b0;

    // Reset values
    #23;
    chk("rst_state", int'(bus.STATE_OUT), 0);
    chk("rst_cpllreset", int'(bus.GT0_CPLLRESET_OUT), 0);
    chk("rst_gttxreset", int'(bus.GT0_GTTXRESET_OUT), 1);
    chk("rst_gtrxreset", int'(bus.GT0_GTRXRESET_OUT), 1);
    chk("rst_userrdy", int'(bus.GT0_TXUSERRDY_OUT), 0);
    chk("rst_done", int'(bus.TX_FSM_RESET_DONE_OUT), 0);
    chk("rst_fail", int'(bus.FAIL_OUT), 0);
    chk("rst_retry", int'(bus.RETRY_COUNT_OUT), 0);

    // 1: nominal bring-up, trace state order and pulse widths
    @(negedge clk);
    rst_n = 1'b1;
    nseq = 1; seq[0] = 0; prev = 0; cpll_hi = 0; gt_hi = 0; first4 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (bus.GT0_CPLLRESET_OUT) cpll_hi++;
      if (int'(bus.STATE_OUT) == 3) gt_hi++;
      if (int'(bus.STATE_OUT) == 4 && first4) begin
        first4 = 1'b0;
        chk("wd_txuserrdy", int'(bus.GT0_TXUSERRDY_OUT), 1);
        chk("wd_rxuserrdy", int'(bus.GT0_RXUSERRDY_OUT), 1);
        chk("wd_gttxreset", int'(bus.GT0_GTTXRESET_OUT), 0);
      end
      if (int'(bus.STATE_OUT) != prev) begin
        prev = int'(bus.STATE_OUT);
        if (nseq < 8) seq[nseq] = prev;
        nseq++;
      end
      if (prev == 5) break;
    end
    chk("nom_nseq", nseq, 6);
    for (int i = 0; i < 6; i++) chk("nom_seq", seq[i], i);
    chk("nom_cpll_width", cpll_hi, 4);
    chk("nom_gtrst_width", gt_hi, 4);
    chk("nom_txdone", int'(bus.TX_FSM_RESET_DONE_OUT), 1);
    chk("nom_rxdone", int'(bus.RX_FSM_RESET_DONE_OUT), 1);
    chk("nom_retry", int'(bus.RETRY_COUNT_OUT), 0);

    // 3: lock drops for 10 cycles while in DONE
    repeat (5) tick();
    lock_kill = 1'b1;
    tick();
    tick();
    chk("ll_hold_txdone", int'(bus.TX_FSM_RESET_DONE_OUT), 1);
    tick();
    chk("ll_txdone", int'(bus.TX_FSM_RESET_DONE_OUT), 0);
    chk("ll_rxdone", int'(bus.RX_FSM_RESET_DONE_OUT), 0);
    chk("ll_userrdy", int'(bus.GT0_TXUSERRDY_OUT), 0);
    chk("ll_state", int'(bus.STATE_OUT), 1);
    chk("ll_retry", int'(bus.RETRY_COUNT_OUT), 1);
    repeat (7) tick();
    lock_kill = 1'b0;
    wait_state(5, 300, "ll_redone");
    chk("ll_fail", int'(bus.FAIL_OUT), 0);
    chk("ll_retry_after", int'(bus.RETRY_COUNT_OUT), 1);

    // 2: lock never asserts
    lock_en = 1'b0;
    soft_pulse();
    chk("sr_state", int'(bus.STATE_OUT), 0);
    chk("sr_retry", int'(bus.RETRY_COUNT_OUT), 0);
    wait_state(2, 100, "nl_wl1");
    dwell(2, 300, n);
    chk("nl_dwell1", n, 100);
    chk("nl_retry1", int'(bus.RETRY_COUNT_OUT), 1);
    chk("nl_state1", int'(bus.STATE_OUT), 1);
    wait_state(2, 20, "nl_wl2");
    dwell(2, 300, n);
    chk("nl_dwell2", n, 100);
    chk("nl_retry2", int'(bus.RETRY_COUNT_OUT), 2);
    chk("nl_state2", int'(bus.STATE_OUT), 7);
    chk("nl_fail", int'(bus.FAIL_OUT), 1);
    chk("nl_cpllreset", int'(bus.GT0_CPLLRESET_OUT), 1);
    chk("nl_gttxreset", int'(bus.GT0_GTTXRESET_OUT), 1);
    chk("nl_gtrxreset", int'(bus.GT0_GTRXRESET_OUT), 1);
    chk("nl_userrdy", int'(bus.GT0_RXUSERRDY_OUT), 0);
    repeat (20) tick();
    chk("nl_fail_sticky", int'(bus.STATE_OUT), 7);

    // 4: soft reset out of FAIL, then nominal
    lock_en = 1'b1;
    soft_pulse();
    chk("fs_state", int'(bus.STATE_OUT), 0);
    chk("fs_retry", int'(bus.RETRY_COUNT_OUT), 0);
    chk("fs_fail", int'(bus.FAIL_OUT), 0);
    chk("fs_cpllreset", int'(bus.GT0_CPLLRESET_OUT), 0);
    chk("fs_gttxreset", int'(bus.GT0_GTTXRESET_OUT), 1);
    wait_state(5, 300, "fs_done");
    chk("fs_txdone", int'(bus.TX_FSM_RESET_DONE_OUT), 1);

    // 5: RXRESETDONE stuck low
    rx_en = 1'b0;
    soft_pulse();
    txdone_seen = 1'b0;
    wait_state(4, 200, "rx_wd");
    dwell(4, 400, n);
    chk("rx_dwell", n, 200);
    chk("rx_retry", int'(bus.RETRY_COUNT_OUT), 1);
    chk("rx_state", int'(bus.STATE_OUT), 1);
    chk("rx_txdone_seen", int'(txdone_seen), 0);
    rx_en = 1'b1;

    // 6: asynchronous reset mid WAIT_LOCK after one retry
    lock_en = 1'b0;
    soft_pulse();
    wait_state(2, 100, "ar_wl1");
    wait_state(1, 200, "ar_cpll");
    wait_state(2, 20, "ar_wl2");
    repeat (10) tick();
    chk("ar_pre_retry", int'(bus.RETRY_COUNT_OUT), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_state", int'(bus.STATE_OUT), 0);
    chk("ar_retry", int'(bus.RETRY_COUNT_OUT), 0);
    chk("ar_cpllreset", int'(bus.GT0_CPLLRESET_OUT), 0);
    chk("ar_gttxreset", int'(bus.GT0_GTTXRESET_OUT), 1);
    chk("ar_gtrxreset", int'(bus.GT0_GTRXRESET_OUT), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      n++;
      if (int'(bus.STATE_OUT) != 0) break;
    end
    chk("ar_init_len", n, 16);
    chk("ar_next_state", int'(bus.STATE_OUT), 1);

    // Table-driven end-state vectors, each started by a soft reset
    for (int v = 0; v < 4; v++) begin
      lock_en = vecs[v].lock_en;
      tx_en   = vecs[v].tx_en;
      rx_en   = vecs[v].rx_en;
      soft_pulse();
      repeat (vecs[v].cycles) tick();
      chk($sformatf("vec%0d_state", v), int'(bus.STATE_OUT), vecs[v].exp_state);
      chk($sformatf("vec%0d_retry", v), int'(bus.RETRY_COUNT_OUT), vecs[v].exp_retry);
      chk($sformatf("vec%0d_fail", v), int'(bus.FAIL_OUT), vecs[v].exp_fail);
      chk($sformatf("vec%0d_txdone", v), int'(bus.TX_FSM_RESET_DONE_OUT), vecs[v].exp_done);
      chk($sformatf("vec%0d_rxdone", v), int'(bus.RX_FSM_RESET_DONE_OUT), vecs[v].exp_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
